// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receive-controller state encoding
package uart_pkg;

  // Two-bit encoding leaves spare codes that the FSM folds back to idle
  typedef enum logic [1:0] {
    RXC_IDLE = 2'd0,
    RXC_CLR  = 2'd1
  } rxc_state_e;

  localparam int UART_DIV_115200 = 27;
  localparam int UART_OVS        = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO between the receive controller and the consumer
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_50m,
  input  logic                     rdy_clr,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               data_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Full/empty come from the registered count, so a same-cycle pop never frees room for a push
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers, emptied by reset
  always_ff @(posedge clk_50m or posedge rdy_clr) begin
    if (rdy_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_50m) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: oversample tick, byte capture, FIFO, overrun, frame end
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV       = UART_DIV_115200,
  parameter int DEPTH     = 8,
  parameter int IDLE_BITS = 20
) (
  input  logic                    clk_50m,
  input  logic                    rdy_clr,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    rx_clken,
  output logic                    rx_rdy_clr,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overrun,
  input  logic                    ovr_clr,
  output logic                    frame_end
);

  localparam logic [15:0] TICK_LAST = 16'(DIV - 1);
  localparam logic [12:0] GAP_LIMIT = 13'(IDLE_BITS * UART_OVS);

  rxc_state_e  state_q, state_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        overrun_q, overrun_d;
  logic        armed_q, armed_d;
  logic [12:0] gap_q, gap_d;
  logic        frame_end_q, frame_end_d;
  logic        push, drop, pop;
  logic        fifo_full, fifo_empty;

  assign rx_clken  = (tick_cnt_q == TICK_LAST);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign overrun   = overrun_q;
  assign frame_end = frame_end_q;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_50m (clk_50m),
    .rdy_clr (rdy_clr),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (rx_data),
    .data_o  (out_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Capture FSM: take the byte once on entry, then hold the clear strobe until rdy falls
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    drop       = 1'b0;
    rx_rdy_clr = 1'b0;
    case (state_q)
      RXC_IDLE: begin
        if (rx_rdy) begin
          push    = !fifo_full;
          drop    = fifo_full;
          state_d = RXC_CLR;
        end
      end
      RXC_CLR: begin
        rx_rdy_clr = 1'b1;
        if (!rx_rdy) state_d = RXC_IDLE;
      end
      default: state_d = RXC_IDLE;
    endcase
  end

  // Tick divider, sticky overrun and idle-gap detector next-state
  always_comb begin
    tick_cnt_d  = rx_clken ? 16'd0 : tick_cnt_q + 16'd1;
    overrun_d   = overrun_q;
    armed_d     = armed_q;
    gap_d       = gap_q;
    frame_end_d = 1'b0;
    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
    if (push || drop) begin
      armed_d = 1'b1;
      gap_d   = '0;
    end else if (armed_q && rx_clken) begin
      gap_d = gap_q + 13'd1;
      if (gap_d == GAP_LIMIT) begin
        frame_end_d = 1'b1;
        armed_d     = 1'b0;
      end
    end
  end

  // Controller state registers
  always_ff @(posedge clk_50m or posedge rdy_clr) begin
    if (rdy_clr) begin
      state_q     <= RXC_IDLE;
      tick_cnt_q  <= '0;
      overrun_q   <= 1'b0;
      armed_q     <= 1'b0;
      gap_q       <= '0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      overrun_q   <= overrun_d;
      armed_q     <= armed_d;
      gap_q       <= gap_d;
      frame_end_q <= frame_end_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic       clk_50m = 1'b0;
  logic       rdy_clr;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       out_ready;
  logic       ovr_clr;

  logic       clken4, rdyclr4, valid4, ovr4, fe4;
  logic [7:0] data4;
  logic [3:0] count4;
  logic       clken27, rdyclr27, valid27, ovr27, fe27;
  logic [7:0] data27;
  logic [3:0] count27;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  bit         m_ovr;
  bit         m_busy;

  always #10 clk_50m = ~clk_50m;

  uart_rx_ctrl #(.DIV(4), .DEPTH(DEPTH), .IDLE_BITS(20)) u_dut4 (
    .clk_50m(clk_50m), .rdy_clr(rdy_clr), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .rx_clken(clken4), .rx_rdy_clr(rdyclr4), .out_data(data4), .out_valid(valid4),
    .out_ready(out_ready), .fifo_count(count4), .overrun(ovr4), .ovr_clr(ovr_clr),
    .frame_end(fe4)
  );

  uart_rx_ctrl #(.DIV(27), .DEPTH(DEPTH), .IDLE_BITS(20)) u_dut27 (
    .clk_50m(clk_50m), .rdy_clr(rdy_clr), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .rx_clken(clken27), .rx_rdy_clr(rdyclr27), .out_data(data27), .out_valid(valid27),
    .out_ready(out_ready), .fifo_count(count27), .overrun(ovr27), .ovr_clr(ovr_clr),
    .frame_end(fe27)
  );

  // Advance one clock; the model applies the byte-handshake and queue rules for this edge
  task automatic tick();
    bit cap, full, popd;
    cap  = rx_rdy && !m_busy;
    full = (q.size() == DEPTH);
    popd = (q.size() != 0) && out_ready;
    if (popd) void'(q.pop_front());
    if (cap && !full) q.push_back(rx_data);
    if (cap && full) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    if (cap) m_busy = 1'b1;
    else if (!rx_rdy) m_busy = 1'b0;
    @(posedge clk_50m);
    #1;
  endtask

  task automatic do_reset();
    rdy_clr = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; out_ready = 1'b0; ovr_clr = 1'b0;
    q.delete(); m_ovr = 1'b0; m_busy = 1'b0;
    repeat (2) @(posedge clk_50m);
    #1;
    rdy_clr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    n_cmp++; if (rdyclr4 !== 1'b1) begin n_err++; $display("FAIL send_clr_rise got=%0b exp=1", rdyclr4); end
    for (int i = 0; i < hold; i++) tick();
    rx_rdy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rdy_clr = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; out_ready = 1'b0; ovr_clr = 1'b0;
    q.delete(); m_ovr = 1'b0; m_busy = 1'b0;
    @(posedge clk_50m);
    #1;
    n_cmp++; if ({clken4, rdyclr4, valid4, ovr4, fe4} !== 5'b0) begin n_err++; $display("FAIL reset_flags4 got=%b exp=00000", {clken4, rdyclr4, valid4, ovr4, fe4}); end
    n_cmp++; if ({clken27, rdyclr27, valid27, ovr27, fe27} !== 5'b0) begin n_err++; $display("FAIL reset_flags27 got=%b exp=00000", {clken27, rdyclr27, valid27, ovr27, fe27}); end
    n_cmp++; if (count4 !== 4'd0 || data4 !== 8'h00) begin n_err++; $display("FAIL reset_fifo got=%0d/%02h exp=0/00", count4, data4); end
    n_cmp++; if (count27 !== 4'd0 || data27 !== 8'h00) begin n_err++; $display("FAIL reset_fifo27 got=%0d/%02h exp=0/00", count27, data27); end
    rdy_clr = 1'b0;
    // cycle c after release (c=1 first) carries the pulse when c is a multiple of DIV
    for (int k = 1; k <= 90; k++) begin
      tick();
      n_cmp++; if (clken27 !== ((k + 1) % 27 == 0)) begin n_err++; $display("FAIL tick27 cycle=%0d got=%0b exp=%0b", k + 1, clken27, ((k + 1) % 27 == 0)); end
      n_cmp++; if (clken4 !== ((k + 1) % 4 == 0)) begin n_err++; $display("FAIL tick4 cycle=%0d got=%0b exp=%0b", k + 1, clken4, ((k + 1) % 4 == 0)); end
      n_cmp++; if ({rdyclr27, valid27, ovr27, fe27, count27} !== 8'h00) begin n_err++; $display("FAIL idle_outputs cycle=%0d got=%b exp=0", k + 1, {rdyclr27, valid27, ovr27, fe27, count27}); end
    end
  endtask

  task automatic test_single_byte();
    do_reset();
    rx_data = 8'hA5;
    rx_rdy  = 1'b1;
    tick();
    n_cmp++; if (rdyclr4 !== 1'b1) begin n_err++; $display("FAIL single_clr got=%0b exp=1", rdyclr4); end
    n_cmp++; if (valid4 !== 1'b1 || data4 !== 8'hA5 || count4 !== 4'd1) begin n_err++; $display("FAIL single_push got=%0b/%02h/%0d exp=1/a5/1", valid4, data4, count4); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (count4 !== 4'd1 || rdyclr4 !== 1'b1) begin n_err++; $display("FAIL single_hold got=%0d/%0b exp=1/1", count4, rdyclr4); end
    end
    rx_rdy = 1'b0;
    tick();
    n_cmp++; if (rdyclr4 !== 1'b0 || count4 !== 4'd1) begin n_err++; $display("FAIL single_release got=%0b/%0d exp=0/1", rdyclr4, count4); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (valid4 !== 1'b0 || count4 !== 4'd0 || data4 !== 8'h00) begin n_err++; $display("FAIL single_pop got=%0b/%0d/%02h exp=0/0/00", valid4, count4, data4); end
  endtask

  task automatic test_fill_overrun();
    do_reset();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), $urandom_range(0, 3));
    n_cmp++; if (count4 !== 4'd8 || ovr4 !== 1'b0) begin n_err++; $display("FAIL fill_count got=%0d/%0b exp=8/0", count4, ovr4); end
    send_byte(8'h09, 1);
    n_cmp++; if (count4 !== 4'd8 || ovr4 !== 1'b1) begin n_err++; $display("FAIL fill_overrun got=%0d/%0b exp=8/1", count4, ovr4); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (valid4 !== 1'b1 || data4 !== 8'(i + 1)) begin n_err++; $display("FAIL drain_order idx=%0d got=%02h exp=%02h", i, data4, 8'(i + 1)); end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (valid4 !== 1'b0 || ovr4 !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%0b/%0b exp=0/1", valid4, ovr4); end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_cmp++; if (ovr4 !== 1'b0) begin n_err++; $display("FAIL ovr_clear got=%0b exp=0", ovr4); end
  endtask

  task automatic test_full_pop();
    logic [7:0] b[8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      b[i] = 8'($urandom);
      send_byte(b[i], 0);
    end
    rx_data = 8'h55; rx_rdy = 1'b1; out_ready = 1'b1; ovr_clr = 1'b1;
    tick();
    n_cmp++; if (count4 !== 4'd7 || ovr4 !== 1'b1) begin n_err++; $display("FAIL fullpop_count got=%0d/%0b exp=7/1", count4, ovr4); end
    n_cmp++; if (data4 !== b[1]) begin n_err++; $display("FAIL fullpop_head got=%02h exp=%02h", data4, b[1]); end
    out_ready = 1'b0; ovr_clr = 1'b0; rx_rdy = 1'b0;
    tick();
    for (int i = 1; i < 8; i++) begin
      n_cmp++; if (data4 !== b[i]) begin n_err++; $display("FAIL fullpop_drain idx=%0d got=%02h exp=%02h", i, data4, b[i]); end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL fullpop_empty got=%0b exp=0", valid4); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!rx_rdy && !m_busy && $urandom_range(0, 2) == 0) begin
        rx_data = 8'($urandom);
        rx_rdy  = 1'b1;
      end else if (rx_rdy && m_busy && $urandom_range(0, 1) == 0) begin
        rx_rdy = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) == 0);
      ovr_clr   = ($urandom_range(0, 15) == 0);
      tick();
      n_cmp++; if (count4 !== 4'(q.size()) || valid4 !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d/%0b exp=%0d", c, count4, valid4, q.size()); end
      n_cmp++; if (data4 !== ((q.size() != 0) ? q[0] : 8'h00)) begin n_err++; $display("FAIL rnd_data cyc=%0d got=%02h", c, data4); end
      n_cmp++; if (ovr4 !== m_ovr) begin n_err++; $display("FAIL rnd_overrun cyc=%0d got=%0b exp=%0b", c, ovr4, m_ovr); end
      n_cmp++; if (rdyclr4 !== m_busy) begin n_err++; $display("FAIL rnd_rdy_clr cyc=%0d got=%0b exp=%0b", c, rdyclr4, m_busy); end
    end
    rx_rdy = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;
    tick();
  endtask

  task automatic test_idle_gap();
    int  ticks;
    int  pulses;
    bit  c;
    do_reset();
    rx_data = 8'($urandom);
    rx_rdy  = 1'b1;
    tick();
    rx_rdy = 1'b0;
    out_ready = 1'b1;
    ticks  = 0;
    pulses = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      c = clken4;
      tick();
      if (c) ticks++;
      if (fe4 === 1'b1) pulses++;
      n_cmp++; if (fe4 !== (c && ticks == 320)) begin n_err++; $display("FAIL frame_end cyc=%0d ticks=%0d got=%0b exp=%0b", cyc, ticks, fe4, (c && ticks == 320)); end
    end
    out_ready = 1'b0;
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL frame_end_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h11, 1);
    send_byte(8'h22, 2);
    rx_data = 8'h33;
    rx_rdy  = 1'b1;
    tick();
    n_cmp++; if (rdyclr4 !== 1'b1 || count4 !== 4'd3) begin n_err++; $display("FAIL mid_setup got=%0b/%0d exp=1/3", rdyclr4, count4); end
    #2;
    rdy_clr = 1'b1;
    #1;
    n_cmp++; if (rdyclr4 !== 1'b0 || valid4 !== 1'b0 || count4 !== 4'd0) begin n_err++; $display("FAIL mid_async got=%0b/%0b/%0d exp=0/0/0", rdyclr4, valid4, count4); end
    do_reset();
    send_byte(8'h3C, 1);
    n_cmp++; if (count4 !== 4'd1 || data4 !== 8'h3C) begin n_err++; $display("FAIL mid_after got=%0d/%02h exp=1/3c", count4, data4); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL mid_only_entry got=%0b exp=0", valid4); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overrun();
    test_full_pop();
    test_random();
    test_idle_gap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
